// File: rtl/mem_fill_responder_if.sv
// rtl/mem_fill_responder_if.sv - fill request, write-through and response signals of the fill responder
interface mem_fill_responder_if;
   logic        req_valid;
   logic [15:0] req_addr;
   logic        req_ready;
   logic        wr_en;
   logic [15:0] wr_addr;
   logic [15:0] wr_data;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [2:0]  rsp_idx;
   logic        rsp_last;
   logic        busy;

   modport master (
      output req_valid, req_addr, wr_en, wr_addr, wr_data,
      input  req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, busy
   );

   modport slave (
      input  req_valid, req_addr, wr_en, wr_addr, wr_data,
      output req_ready, rsp_valid, rsp_data, rsp_idx, rsp_last, busy
   );
endinterface

// File: rtl/mem_fill_responder.sv
// rtl/mem_fill_responder.sv - main-memory responder streaming 8-word cache fill blocks after a fixed latency
module mem_fill_responder #(
   parameter int LATENCY     = 4,
   parameter int BLOCK_WORDS = 8,
   parameter int MEM_AW      = 15
) (
   input logic clk,
   input logic rst,
   mem_fill_responder_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT, STREAM} state_t;

   localparam logic [3:0] LAT_LOAD  = 4'(LATENCY - 1);
   localparam logic [2:0] LAST_BEAT = 3'(BLOCK_WORDS - 1);
   localparam logic       DIRECT    = (LATENCY == 1);

   state_t      state, state_nxt;
   logic [3:0]  lat_cnt, lat_cnt_nxt;
   logic [2:0]  beat, beat_nxt;
   logic [11:0] base, base_nxt;
   logic        beat_fire;

   logic        rsp_valid_q;
   logic [15:0] rsp_data_q;
   logic [2:0]  rsp_idx_q;
   logic        rsp_last_q;

   logic [15:0]       mem [0:(1 << MEM_AW) - 1];
   logic [MEM_AW-1:0] rd_word;
   logic [MEM_AW-1:0] wr_word;
   logic              unused_addr_bits;

   assign rd_word          = {base, beat};
   assign wr_word          = bus.wr_addr[15:1];
   assign unused_addr_bits = ^{bus.req_addr[3:0], bus.wr_addr[0]};

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      beat_nxt    = beat;
      base_nxt    = base;
      beat_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.req_valid) begin
               base_nxt    = bus.req_addr[15:4];
               lat_cnt_nxt = LAT_LOAD;
               beat_nxt    = '0;
               state_nxt   = DIRECT ? STREAM : WAIT;
            end
         end
         WAIT: begin
            // Leaving on the edge that takes the counter to zero puts beat 0 exactly LATENCY edges after acceptance.
            lat_cnt_nxt = lat_cnt - 4'd1;
            if (lat_cnt_nxt == 4'd0) begin
               state_nxt = STREAM;
            end
         end
         STREAM: begin
            beat_fire = 1'b1;
            beat_nxt  = beat + 3'd1;
            if (beat == LAST_BEAT) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         lat_cnt     <= '0;
         beat        <= '0;
         base        <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_idx_q   <= '0;
         rsp_last_q  <= 1'b0;
      end else begin
         state       <= state_nxt;
         lat_cnt     <= lat_cnt_nxt;
         beat        <= beat_nxt;
         base        <= base_nxt;
         rsp_valid_q <= beat_fire;
         rsp_last_q  <= beat_fire && (beat == LAST_BEAT);
         if (beat_fire) begin
            rsp_data_q <= mem[rd_word];
            rsp_idx_q  <= beat;
         end
      end
   end

   // Storage survives reset; a same-edge write is seen by the beat read as the old word.
   always_ff @(posedge clk) begin
      if (bus.wr_en) begin
         mem[wr_word] <= bus.wr_data;
      end
   end

   assign bus.req_ready = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.rsp_idx   = rsp_idx_q;
   assign bus.rsp_last  = rsp_last_q;
endmodule
